// File: rtl/i2s_dac_tx.sv
// I2S transmitter: derives MCLK, SCLK and LRCK from the system clock and shifts out
// 16-bit stereo samples in a 64-bit frame (two 32-bit slots, one-bit I2S delay).
module i2s_dac_tx #(
  parameter int MCLK_DIV     = 4,
  parameter int CLK_PER_BCLK = 16,
  parameter int DATA_W       = 16,
  parameter bit UNSIGNED_IN  = 1'b0
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] L_data,
  input  logic [DATA_W-1:0] R_data,
  input  logic              mute,
  output logic              dac_MCLK,
  output logic              dac_SCLK,
  output logic              dac_LRCK,
  output logic              dac_SDIN,
  output logic              sample_strobe
);

  localparam int MW = $clog2(MCLK_DIV);
  localparam int DW = $clog2(CLK_PER_BCLK);
  localparam logic [DATA_W-1:0] MSB_FLIP =
    UNSIGNED_IN ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  logic [MW-1:0]     mclk_cnt, mclk_nxt;
  logic [DW-1:0]     div_cnt, div_nxt;
  logic [5:0]        bit_cnt, bit_nxt;
  logic              div_wrap, boundary;
  logic [4:0]        slot_pos;
  logic [DATA_W-1:0] hold_l, hold_r, hold_sel, shifted;
  logic [DATA_W-1:0] lat_l, lat_r;
  logic              sdin_nxt;

  always_comb begin
    mclk_nxt = (mclk_cnt == MW'(MCLK_DIV - 1)) ? '0 : mclk_cnt + 1'b1;
    div_wrap = (div_cnt == DW'(CLK_PER_BCLK - 1));
    div_nxt  = div_wrap ? '0 : div_cnt + 1'b1;
    bit_nxt  = div_wrap ? bit_cnt + 6'd1 : bit_cnt;
    boundary = div_wrap && (bit_cnt == 6'd63);

    // Slot position 0 is the I2S delay bit; positions 1..DATA_W carry MSB..LSB.
    slot_pos = bit_nxt[4:0];
    hold_sel = bit_nxt[5] ? hold_r : hold_l;
    shifted  = hold_sel << (slot_pos - 5'd1);
    sdin_nxt = 1'b0;
    if ((slot_pos != 5'd0) && ({27'd0, slot_pos} <= DATA_W))
      sdin_nxt = shifted[DATA_W-1];

    lat_l = mute ? '0 : (L_data ^ MSB_FLIP);
    lat_r = mute ? '0 : (R_data ^ MSB_FLIP);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      mclk_cnt      <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      dac_MCLK      <= 1'b0;
      dac_SCLK      <= 1'b0;
      dac_LRCK      <= 1'b0;
      dac_SDIN      <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      mclk_cnt      <= mclk_nxt;
      div_cnt       <= div_nxt;
      bit_cnt       <= bit_nxt;
      dac_MCLK      <= (mclk_nxt >= MW'(MCLK_DIV / 2));
      dac_SCLK      <= (div_nxt >= DW'(CLK_PER_BCLK / 2));
      sample_strobe <= boundary;
      if (boundary) begin
        hold_l <= lat_l;
        hold_r <= lat_r;
      end
      // LRCK and data move on the same edge that drives SCLK low.
      if (div_wrap) begin
        dac_LRCK <= bit_nxt[5];
        dac_SDIN <= sdin_nxt;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: clock/reset timing, frame contents, no-tearing,
// mute, offset-binary conversion and mid-frame reset.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] L, R, L1, R1;
  logic        mute;
  logic        mclk0, sclk0, lrck0, sdin0, strobe0;
  logic        mclk1, sclk1, lrck1, sdin1, strobe1;

  int tests_run = 0;
  int tests_failed = 0;

  always #10 clk = ~clk;

  i2s_dac_tx dut0 (
    .clk_50MHz(clk), .reset(reset), .L_data(L), .R_data(R), .mute(mute),
    .dac_MCLK(mclk0), .dac_SCLK(sclk0), .dac_LRCK(lrck0), .dac_SDIN(sdin0),
    .sample_strobe(strobe0)
  );

  i2s_dac_tx #(.UNSIGNED_IN(1'b1)) dut1 (
    .clk_50MHz(clk), .reset(reset), .L_data(L1), .R_data(R1), .mute(mute),
    .dac_MCLK(mclk1), .dac_SCLK(sclk1), .dac_LRCK(lrck1), .dac_SDIN(sdin1),
    .sample_strobe(strobe1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts negedges until dut0 strobes; bounded so a dead strobe cannot hang the run.
  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!strobe0 && k < 3000);
  endtask

  // Starts on the negedge where the strobe is high; samples every SCLK rising edge.
  task automatic capture(output logic [63:0] sd0, output logic [63:0] sd1,
                         output logic [63:0] lr, output int strobes, output logic sclk_hi,
                         input int chg_bit, input logic [15:0] chg_l, input logic [15:0] chg_r);
    sd0 = '0; sd1 = '0; lr = '0; strobes = 0; sclk_hi = 1'b1;
    for (int b = 0; b < 64; b++) begin
      if (b == chg_bit) begin
        L = chg_l;
        R = chg_r;
      end
      repeat ((b == 0) ? 8 : 16) begin
        @(negedge clk);
        if (strobe0) strobes++;
      end
      sd0[63-b] = sdin0;
      sd1[63-b] = sdin1;
      lr[63-b]  = lrck0;
      sclk_hi   = sclk_hi & sclk0;
    end
  endtask

  function automatic logic [63:0] frame(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
  endfunction

  localparam logic [63:0] LRCK_PAT = {32'h0000_0000, 32'hFFFF_FFFF};

  initial begin
    logic [63:0] sd0, sd1, lr;
    logic [15:0] mclk_v, sclk_v;
    logic        sclk_hi;
    int          k, strobes;

    // Clock/reset
    reset = 1'b1; mute = 1'b0;
    L = 16'hA5C3; R = 16'h0001; L1 = 16'h8000; R1 = 16'h0000;
    repeat (5) @(negedge clk);
    check("reset_outputs", {59'd0, mclk0, sclk0, lrck0, sdin0, strobe0}, 64'd0);
    reset = 1'b0;

    mclk_v = '0; sclk_v = '0; k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k <= 16) begin
        mclk_v[k-1] = mclk0;
        sclk_v[k-1] = sclk0;
      end
    end while (!strobe0 && k < 3000);
    check("mclk_pattern", 64'(mclk_v), 64'h6666);
    check("sclk_pattern", 64'(sclk_v), 64'h7F80);
    check("first_strobe", 64'(k), 64'd1024);

    // Frame with A5C3/0001; the offset-binary instance converts 8000/0000
    capture(sd0, sd1, lr, strobes, sclk_hi, -1, 16'h0, 16'h0);
    check("frame_a5c3", sd0, frame(16'hA5C3, 16'h0001));
    check("lrck_pattern", lr, LRCK_PAT);
    check("sclk_high_at_sample", 64'(sclk_hi), 64'd1);
    check("unsigned_frame", sd1, frame(16'h0000, 16'h8000));
    check("strobe_one_cycle", 64'(strobes), 64'd0);

    // Mid-frame change must not tear the frame in flight
    L = 16'h1234;
    wait_strobe(k);
    check("strobe_period", 64'(k), 64'd8);
    capture(sd0, sd1, lr, strobes, sclk_hi, 10, 16'hFFFF, 16'h0001);
    check("no_tear_1234", sd0, frame(16'h1234, 16'h0001));
    wait_strobe(k);
    check("strobe_period2", 64'(k), 64'd8);
    capture(sd0, sd1, lr, strobes, sclk_hi, 5, 16'h7FFF, 16'h7FFF);
    check("next_ffff", sd0, frame(16'hFFFF, 16'h0001));

    // Mute asserted only during the boundary cycle
    repeat (7) @(negedge clk);
    mute = 1'b1;
    @(negedge clk);
    mute = 1'b0;
    check("mute_strobe", 64'(strobe0), 64'd1);
    capture(sd0, sd1, lr, strobes, sclk_hi, -1, 16'h0, 16'h0);
    check("muted_frame", sd0, 64'd0);
    check("muted_lrck", lr, LRCK_PAT);
    wait_strobe(k);
    check("strobe_period3", 64'(k), 64'd8);
    capture(sd0, sd1, lr, strobes, sclk_hi, -1, 16'h0, 16'h0);
    check("unmuted_7fff", sd0, frame(16'h7FFF, 16'h7FFF));

    // One-cycle reset at bit 40 of a frame
    wait_strobe(k);
    repeat (640) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {59'd0, mclk0, sclk0, lrck0, sdin0, strobe0}, 64'd0);
    check("midreset_counters", {40'd0, 8'(dut0.bit_cnt), 8'(dut0.div_cnt), 8'(dut0.mclk_cnt)}, 64'd0);
    reset = 1'b0;
    wait_strobe(k);
    check("strobe_after_reset", 64'(k), 64'd1024);
    capture(sd0, sd1, lr, strobes, sclk_hi, -1, 16'h0, 16'h0);
    check("frame_after_reset", sd0, frame(16'h7FFF, 16'h7FFF));
    check("lrck_after_reset", lr, LRCK_PAT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
